// File: rtl/lca_pkg.sv
// ============================================================================
// Module      : lca_pkg
// Description : Shared opcode constants, widths and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lca_pkg;

    localparam int IR_W   = 16;
    localparam int LIST_W = 8;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } lmsm_state_t;

endpackage

`default_nettype wire

// File: rtl/lsb_encoder.sv
// ============================================================================
// Module      : lsb_encoder
// Description : Index and one-hot of the lowest set bit of a vector, plus none.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_encoder #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [W-1:0]     onehot_o,
    output logic             none_o
);

    // Scanning from the top lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign onehot_o = vec_i & (~vec_i + W'(1));
    assign none_o   = (vec_i == '0);

endmodule

`default_nettype wire

// File: rtl/lmsm_sequencer.sv
// ============================================================================
// Module      : lmsm_sequencer
// Description : Expands LM/SM into one single-register micro-op per list bit.
//               Optional stall counter enabled by LMSM_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lmsm_sequencer #(
    parameter int IR_W   = 16,
    parameter int LIST_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] ir_in,
    input  logic            stall_in,
    input  logic            flush,
    output logic [IR_W-1:0] ir_out,
    output logic            first_multiple,
    output logic [2:0]      reg_idx,
    output logic            pc_write,
    output logic            if_id_hold,
    output logic            busy
`ifdef LMSM_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    import lca_pkg::*;

    localparam int c_HI_W = IR_W - LIST_W;

    lmsm_state_t             state_q, state_d;
    logic [LIST_W-1:0]       mask_q, mask_d;
    logic [c_HI_W-1:0]       irhi_q, irhi_d;

    logic [LIST_W-1:0]       w_enc_vec;
    logic [2:0]              w_enc_idx;
    logic [LIST_W-1:0]       w_enc_onehot;
    logic                    w_enc_none;
    logic [LIST_W-1:0]       w_rem;
    logic                    w_is_lmsm;
    logic                    w_hold;

    // One encoder serves both the incoming list and the working mask.
    assign w_enc_vec = (state_q == SEQ) ? mask_q : ir_in[LIST_W-1:0];
    assign w_rem     = w_enc_vec & ~w_enc_onehot;
    assign w_is_lmsm = (ir_in[IR_W-1 -: 4] == OP_LM) || (ir_in[IR_W-1 -: 4] == OP_SM);

    lsb_encoder #(
        .W     (LIST_W),
        .IDX_W (3)
    ) u_lsb_encoder (
        .vec_i    (w_enc_vec),
        .idx_o    (w_enc_idx),
        .onehot_o (w_enc_onehot),
        .none_o   (w_enc_none)
    );

    always_comb begin
        ir_out         = ir_in;
        first_multiple = 1'b0;
        reg_idx        = 3'd0;
        w_hold         = 1'b0;
        state_d        = state_q;
        mask_d         = mask_q;
        irhi_d         = irhi_q;
        if (reset) begin
            state_d = IDLE;
        end else if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_is_lmsm && !w_enc_none) begin
                        ir_out         = {ir_in[IR_W-1:LIST_W], w_enc_onehot};
                        first_multiple = 1'b1;
                        reg_idx        = w_enc_idx;
                        if (w_rem != '0) begin
                            w_hold = 1'b1;
                            if (!stall_in) begin
                                mask_d  = w_rem;
                                irhi_d  = ir_in[IR_W-1:LIST_W];
                                state_d = SEQ;
                            end
                        end
                    end
                end
                SEQ: begin
                    ir_out  = {irhi_q, w_enc_onehot};
                    reg_idx = w_enc_idx;
                    w_hold  = (w_rem != '0);
                    if (!stall_in) begin
                        mask_d = w_rem;
                        if (w_rem == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            irhi_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            irhi_q  <= irhi_d;
        end
    end

    assign pc_write   = !w_hold;
    assign if_id_hold = w_hold;
    assign busy       = !reset && (state_q == SEQ);

`ifdef LMSM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = reset ? 16'd0 : stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
// ============================================================================
// Module      : tb_lmsm_sequencer
// Description : Directed self-checking bench for lmsm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic        stall_in;
    logic        flush;
    logic [15:0] ir_out;
    logic        first_multiple;
    logic [2:0]  reg_idx;
    logic        pc_write;
    logic        if_id_hold;
    logic        busy;
`ifdef LMSM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    logic [22:0] exp_v;
    wire  [22:0] obs = {ir_out, first_multiple, reg_idx, pc_write, if_id_hold, busy};

    always #5 clk = ~clk;

    lmsm_sequencer #(
        .IR_W   (16),
        .LIST_W (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .stall_in       (stall_in),
        .flush          (flush),
        .ir_out         (ir_out),
        .first_multiple (first_multiple),
        .reg_idx        (reg_idx),
        .pc_write       (pc_write),
        .if_id_hold     (if_id_hold),
        .busy           (busy)
`ifdef LMSM_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ir_in = 16'h1234;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ir_in = 16'h7EFF; stall_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_total++; exp_v = {16'h7EFF, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL reset_pass obs=%h exp=%h", obs, exp_v); else n_pass++;
`ifdef LMSM_STALL_CNT_EN
        n_total++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_cnt obs=%h exp=0", stall_cnt); else n_pass++;
`endif
        tick();
        reset = 1'b0; ir_in = 16'h1234;
    endtask

    task automatic test_lm_two();
        ir_in = 16'h6403;
        @(negedge clk);
        n_total++; exp_v = {16'h6401, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL lm2_c0 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; exp_v = {16'h6402, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        if (obs !== exp_v) $display("FAIL lm2_c1 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL lm2_c2 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    task automatic test_sm_full();
        int low_cnt = 0;
        do_reset();
        ir_in = 16'h7EFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            exp_v = {8'h7E, 8'(1 << k), (k == 0), 3'(k), (k == 7), (k != 7), (k != 0)};
            if (obs !== exp_v) $display("FAIL sm8_c%0d obs=%h exp=%h", k, obs, exp_v); else n_pass++;
            if (!pc_write) low_cnt++;
            tick();
        end
        ir_in = 16'h1234;
        @(negedge clk);
        n_total++;
        if (low_cnt != 7) $display("FAIL sm8_lowcnt obs=%0d exp=7", low_cnt); else n_pass++;
`ifdef LMSM_STALL_CNT_EN
        n_total++;
        if (stall_cnt !== 16'd7) $display("FAIL sm8_cnt obs=%0d exp=7", stall_cnt); else n_pass++;
`endif
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL sm8_after obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        ir_in = 16'h6080;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_total++; exp_v = {16'h6080, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
            if (obs !== exp_v) $display("FAIL single_c%0d obs=%h exp=%h", k, obs, exp_v); else n_pass++;
            tick();
        end
        ir_in = 16'h1234;
    endtask

    task automatic test_passthrough();
        ir_in = 16'h6000;
        @(negedge clk);
        n_total++; exp_v = {16'h6000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL pass_empty obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL pass_add obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        ir_in = 16'h6403; stall_in = 1'b1;
        @(negedge clk);
        n_total++; exp_v = {16'h6401, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL stall_idle obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        stall_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== exp_v) $display("FAIL stall_c0 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        for (int k = 1; k <= 3; k++) begin
            stall_in = (k != 3);
            @(negedge clk);
            n_total++; exp_v = {16'h6402, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
            if (obs !== exp_v) $display("FAIL stall_c%0d obs=%h exp=%h", k, obs, exp_v); else n_pass++;
            tick();
        end
        stall_in = 1'b0; ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL stall_c4 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        ir_in = 16'h6403;
        @(negedge clk);
        n_total++; exp_v = {16'h6401, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL b2b_c0 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        ir_in = 16'h7003;
        @(negedge clk);
        n_total++; exp_v = {16'h6402, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        if (obs !== exp_v) $display("FAIL b2b_c1 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; exp_v = {16'h7001, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        if (obs !== exp_v) $display("FAIL b2b_c2 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; exp_v = {16'h7002, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        if (obs !== exp_v) $display("FAIL b2b_c3 obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        ir_in = 16'h1234;
    endtask

    task automatic test_flush();
        ir_in = 16'h7EFF;
        tick();
        tick();
        @(negedge clk);
        n_total++; exp_v = {16'h7E04, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1};
        if (obs !== exp_v) $display("FAIL flush_pre obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        flush = 1'b1; ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs[22:1] !== exp_v[22:1]) $display("FAIL flush_cyc obs=%h exp=%h", obs[22:1], exp_v[22:1]); else n_pass++;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_next obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        flush = 1'b1; ir_in = 16'h6403;
        @(negedge clk);
        n_total++; exp_v = {16'h6403, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL flush_idle obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        flush = 1'b0; ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL flush_nocap obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        ir_in = 16'h7EFF;
        tick();
        tick();
        tick();
        reset = 1'b1; ir_in = 16'h1234;
        @(negedge clk);
        n_total++; exp_v = {16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        if (obs !== exp_v) $display("FAIL rstmid_cyc obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== exp_v) $display("FAIL rstmid_next obs=%h exp=%h", obs, exp_v); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_lm_two();
        test_sm_full();
        test_single();
        test_passthrough();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Expands IITB-RISC load-multiple (LM) and store-multiple (SM) instructions into one single-register micro-op per set bit of the 8-bit register list. Sits between the IF/ID pipeline register and the decode stage: it consumes the fetched instruction, presents decode with a micro-op IR plus the `first_multiple` flag, and holds fetch and the IF/ID register until the expansion completes. Non-LM/SM instructions pass through unchanged in the same cycle.

## Interface
Parameters:
- `IR_W`, 16, instruction width
- `LIST_W`, 8, register-list width (one bit per R0..R7)

Ports:
- `clk`  in  1  clock. All state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ir_in`  in  16  instruction from the IF/ID register (`pr1_IR`).
- `stall_in`  in  1  hazard-unit stall; freezes the sequencer.
- `flush`  in  1  IF/ID flush (branch/jump resolved).
- `ir_out`  out  16  micro-op IR to decode.
- `first_multiple`  out  1  high on the first micro-op of an LM/SM. Selects the RF base address; later micro-ops use the incremented address.
- `reg_idx`  out  3  register index of the current micro-op.
- `pc_write`  out  1  low = hold the PC.
- `if_id_hold`  out  1  high = IF/ID register keeps its contents.
- `busy`  out  1  high while in SEQ.
- `stall_cnt`  out  16  present only with `LMSM_STALL_CNT_EN`.

## Operation
- Decoded fields: `op = ir_in[15:12]`; LM = 4'b0110, SM = 4'b0111; `list = ir_in[7:0]`.
- Micro-op encoding: `ir_out = {IR[15:8], onehot(reg_idx)}`. Opcode, RA and bit 8 are kept; the list field is replaced by the one-hot of the current register.
- Registers are processed in ascending order (R0 first). `reg_idx` is the lowest set bit of the working mask.
- State machine:
  - IDLE
    - `ir_in` is not LM/SM, or the list is zero: pass-through. `ir_out = ir_in`, `first_multiple = 0`, `reg_idx = 0`.
    - LM/SM with popcount 1: emit that single micro-op with `first_multiple = 1`. Stay in IDLE and do not hold.
    - LM/SM with popcount ≥ 2: emit the micro-op for the lowest bit with `first_multiple = 1`. Store the list with that bit cleared in `mask_q`, store `ir_in[15:8]`, assert the hold, and go to SEQ.
  - SEQ
    - Emit the micro-op for the lowest bit of `mask_q`, with `first_multiple = 0`, then clear that bit.
    - If `mask_q` has exactly one bit set, this is the last micro-op: release the hold this cycle and go to IDLE next.
- Hold outputs: `pc_write = !hold`, `if_id_hold = hold`.
  - `hold` is high in IDLE when capturing a multi-bit list.
  - `hold` is high in SEQ except on the last micro-op.
- Priority order: `reset` > `flush` > `stall_in` > normal operation.
  - `flush`: go to IDLE and clear `mask_q`. In that cycle outputs are pass-through and there is no capture, even if `ir_in` is LM/SM.
  - `stall_in`: state, `mask_q` and all outputs are frozen.

## Timing
- Combinational (Mealy) outputs. Zero latency from `ir_in` to `ir_out` in IDLE.
- An N-bit list takes N cycles of micro-ops and N−1 cycles with `pc_write` low. Each stalled cycle adds one cycle.
- The instruction following LM/SM is presented by IF/ID in the cycle after the last micro-op.
- Reset behaviour:
  - State goes to IDLE, `mask_q = 0`, and the stored IR goes to 0.
  - While `reset` is high, outputs are pass-through: `ir_out = ir_in`, `first_multiple = 0`, `reg_idx = 0`, `pc_write = 1`, `if_id_hold = 0`, `busy = 0`, `stall_cnt = 0`.
- A reset in the middle of an expansion abandons it. The next cycle is IDLE.

## Configuration
- `LMSM_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` port and a 16-bit counter.
  - The counter increments on every cycle with `pc_write == 0` and saturates at 16'hFFFF.
  - It is cleared only by `reset`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `lca_pkg`:
  - Opcode constants `OP_LM` and `OP_SM`.
  - `IR_W`.
  - State enum `lmsm_state_t` {IDLE, SEQ}.
- Sub-module `lsb_encoder`: 8-bit input, producing a 3-bit index of the lowest set bit, a one-hot of that bit, and `none`. It is instantiated once and shared between the `ir_in` path and the `mask_q` path through a mux.

## Test plan
- LM RA=2, list 0x03 (`ir_in` = 16'h6403 held):
  - Cycle 0: `ir_out` = 16'h6401, `first_multiple` = 1, `reg_idx` = 0, `pc_write` = 0.
  - Cycle 1: `ir_out` = 16'h6402, `first_multiple` = 0, `reg_idx` = 1, `pc_write` = 1.
  - Cycle 2: `busy` = 0.
- SM RA=7, list 0xFF (16'h7EFF):
  - 8 micro-ops with `reg_idx` 0..7 and one-hot 01, 02 .. 80.
  - `pc_write` low for exactly 7 cycles. `stall_cnt` = 7 when `LMSM_STALL_CNT_EN` is defined.
- LM list 0x80 (16'h6080):
  - One cycle: `ir_out` = 16'h6080, `first_multiple` = 1, `reg_idx` = 7, `pc_write` = 1, `busy` stays 0.
- Pass-through cases, with `ir_out == ir_in`, `first_multiple` = 0 and `pc_write` = 1:
  - Empty list 16'h6000.
  - ADD 16'h1234.
- Stall: 16'h6403 with `stall_in` = 1 for 2 cycles starting in cycle 1.
  - `ir_out` = 16'h6402 for 3 cycles and `busy` = 1 throughout.
  - The sequencer returns to IDLE in cycle 4.
- Flush/reset during SEQ of 16'h7EFF at `reg_idx` 3:
  - On `flush` (or `reset`), the next cycle has `busy` = 0 and `pc_write` = 1.
  - With `ir_in` = 16'h1234, `ir_out` = 16'h1234.
